// File: rtl/dmem_stage_ctrl.sv
// dmem_stage_ctrl: memory-stage controller for the pipelined MIPS core.
// Turns lw/sw/lb/lbu/sb from EX/MEM into a req/ack data-memory transaction,
// stalls the pipeline while the transaction is outstanding, aligns and
// extends load data, and flags illegal accesses and memory timeouts.

module dmem_stage_ctrl #(
    parameter int TIMEOUT = 15              // REQ cycles without ack before abort (1..255)
) (
    input  logic        clk,
    input  logic        reset,              // asynchronous, active-low
    input  logic        memread_m,
    input  logic        memwrite_m,
    input  logic        byte_m,
    input  logic        unsigned_m,
    input  logic [31:0] aluout_m,
    input  logic [31:0] writedata_m,
    output logic        stall_m,
    output logic [31:0] readdata_m,
    output logic        err_m,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    // Last REQ cycle index before the transaction is declared dead.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_count;        // REQ cycles spent without ack
    logic [1:0]  r_lane;         // byte lane of the latched access
    logic        r_is_load;
    logic        r_is_byte;
    logic        r_is_unsigned;

    logic        w_op_any;
    logic        w_op_legal;
    logic        w_op_illegal;
    logic [3:0]  w_be_byte;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_lanes [4];
    logic [7:0]  w_lane_sel;
    logic [31:0] w_load_data;
    logic        w_timeout;

    // Request classification: exactly one of read/write, words must be aligned.
    assign w_op_any     = memread_m | memwrite_m;
    assign w_op_legal   = (memread_m ^ memwrite_m) && (byte_m || (aluout_m[1:0] == 2'b00));
    assign w_op_illegal = w_op_any && !w_op_legal;

    // Per-lane byte enable decode and read-data lane split.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_be_byte[gi] = (aluout_m[1:0] == 2'(gi));
            assign w_lanes[gi]   = mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign w_be    = byte_m ? w_be_byte : 4'b1111;
    // A byte store drives the same byte on every lane; the enables pick the target.
    assign w_wdata = byte_m ? {4{writedata_m[7:0]}} : writedata_m;

    // Load alignment uses the lane latched at issue, not the live address.
    assign w_lane_sel  = w_lanes[r_lane];
    assign w_load_data = !r_is_byte    ? mem_rdata :
                         r_is_unsigned ? {24'b0, w_lane_sel} :
                                         {{24{w_lane_sel[7]}}, w_lane_sel};

    assign w_timeout = (r_count == TO_LAST);

    // Stall is combinational so the op is frozen in its very first IDLE cycle;
    // gated by reset so it drops the moment reset is asserted.
    assign stall_m = reset && (((r_state == S_IDLE) && w_op_legal) || (r_state == S_REQ));

    // Transaction FSM with all memory-side and result outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_count       <= 8'd0;
            r_lane        <= 2'd0;
            r_is_load     <= 1'b0;
            r_is_byte     <= 1'b0;
            r_is_unsigned <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 30'd0;
            mem_be        <= 4'd0;
            mem_wdata     <= 32'd0;
            readdata_m    <= 32'd0;
            err_m         <= 1'b0;
        end else begin
            err_m <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_op_legal) begin
                        mem_req       <= 1'b1;
                        mem_we        <= memwrite_m;
                        mem_addr      <= aluout_m[31:2];
                        mem_be        <= w_be;
                        mem_wdata     <= w_wdata;
                        r_lane        <= aluout_m[1:0];
                        r_is_load     <= memread_m;
                        r_is_byte     <= byte_m;
                        r_is_unsigned <= unsigned_m;
                        r_count       <= 8'd0;
                        r_state       <= S_REQ;
                    end else if (w_op_illegal) begin
                        // Never issued: report and let the pipeline move on.
                        err_m      <= 1'b1;
                        readdata_m <= 32'd0;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        // An ack on the timeout cycle still counts as success.
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        r_count <= 8'd0;
                        if (r_is_load) begin
                            readdata_m <= w_load_data;
                        end
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        r_count    <= 8'd0;
                        readdata_m <= 32'd0;
                        err_m      <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                S_DONE: begin
                    // Pipeline advances this cycle; the next op is seen in IDLE.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_stage_ctrl.sv
// Self-checking bench for dmem_stage_ctrl: directed scenarios plus a
// randomized run checked against a transaction-level reference model.

module tb_dmem_stage_ctrl;

    localparam int TO = 15;

    logic        clk;
    logic        reset;
    logic        memread_m, memwrite_m, byte_m, unsigned_m;
    logic [31:0] aluout_m, writedata_m;
    logic        stall_m;
    logic [31:0] readdata_m;
    logic        err_m, mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_stage_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .memread_m(memread_m), .memwrite_m(memwrite_m), .byte_m(byte_m), .unsigned_m(unsigned_m),
        .aluout_m(aluout_m), .writedata_m(writedata_m),
        .stall_m(stall_m), .readdata_m(readdata_m), .err_m(err_m),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one op (called at posedge+1) and observes the whole transaction.
    // ack_at = REQ cycle number (1-based) on which mem_ack is driven, 0 = never.
    task automatic run_op(input logic rd, input logic wr, input logic byt, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] rdata,
                          output int n_stall, output int n_req, output int n_errp,
                          output logic [31:0] rd_out, output logic we_o, output logic [29:0] addr_o,
                          output logic [3:0] be_o, output logic [31:0] wd_o,
                          output bit unstable, output bit hung);
        logic s;
        n_stall = 0; n_req = 0; n_errp = 0; unstable = 0; hung = 1;
        we_o = 0; addr_o = '0; be_o = '0; wd_o = '0;
        memread_m = rd; memwrite_m = wr; byte_m = byt; unsigned_m = uns;
        aluout_m = addr; writedata_m = wd;
        for (int c = 0; c < 64; c++) begin
            mem_ack   = (ack_at != 0) && (c == ack_at);
            mem_rdata = mem_ack ? rdata : $urandom;
            @(negedge clk);
            s = stall_m;
            if (stall_m) n_stall++;
            if (err_m) n_errp++;
            if (mem_req) begin
                n_req++;
                if (n_req == 1) begin
                    we_o = mem_we; addr_o = mem_addr; be_o = mem_be; wd_o = mem_wdata;
                end else if (mem_we !== we_o || mem_addr !== addr_o || mem_be !== be_o || mem_wdata !== wd_o) begin
                    unstable = 1;
                end
            end
            @(posedge clk); #1;
            if (!s) begin
                hung = 0;
                break;
            end
        end
        memread_m = 0; memwrite_m = 0; byte_m = 0; unsigned_m = 0;
        mem_ack = 0;
        @(negedge clk);
        if (err_m) n_errp++;
        rd_out = readdata_m;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 0;
        memread_m = 1; memwrite_m = 0; byte_m = 0; unsigned_m = 0;
        aluout_m = 32'h100; writedata_m = 32'h55; mem_ack = 1; mem_rdata = 32'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (stall_m !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", stall_m); end
        n_cmp++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || err_m !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl: req=%b we=%b err=%b expected 0", mem_req, mem_we, err_m); end
        n_cmp++; if (mem_addr !== 30'd0 || mem_be !== 4'd0 || mem_wdata !== 32'd0 || readdata_m !== 32'd0) begin n_bad++; $display("FAIL reset_data: addr=%h be=%h wd=%h rd=%h expected all 0", mem_addr, mem_be, mem_wdata, readdata_m); end
        memread_m = 0; mem_ack = 0;
        @(posedge clk); #2;
        reset = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_word();
        int ns, nr, ne; logic [31:0] ro, wo; logic we; logic [29:0] a; logic [3:0] be; bit un, hg;
        run_op(0, 1, 0, 0, 32'h8, 32'h04ee9112, 1, 32'h0, ns, nr, ne, ro, we, a, be, wo, un, hg);
        n_cmp++; if (a !== 30'd2) begin n_bad++; $display("FAIL sw_addr: got %h expected 2", a); end
        n_cmp++; if (be !== 4'b1111) begin n_bad++; $display("FAIL sw_be: got %b expected 1111", be); end
        n_cmp++; if (we !== 1'b1) begin n_bad++; $display("FAIL sw_we: got %b expected 1", we); end
        n_cmp++; if (wo !== 32'h04ee9112) begin n_bad++; $display("FAIL sw_wdata: got %h expected 04ee9112", wo); end
        n_cmp++; if (ns !== 2 || nr !== 1 || hg) begin n_bad++; $display("FAIL sw_timing: stall=%0d req=%0d hung=%0b expected 2/1/0", ns, nr, hg); end
        n_cmp++; if (ne !== 0) begin n_bad++; $display("FAIL sw_err: got %0d pulses expected 0", ne); end
    endtask

    task automatic test_byte_ops();
        int ns, nr, ne; logic [31:0] ro, wo; logic we; logic [29:0] a; logic [3:0] be; bit un, hg;
        run_op(0, 1, 1, 0, 32'h19, 32'h000000ab, 1, 32'h0, ns, nr, ne, ro, we, a, be, wo, un, hg);
        n_cmp++; if (be !== 4'b0010) begin n_bad++; $display("FAIL sb_be: got %b expected 0010", be); end
        n_cmp++; if (wo !== 32'habababab) begin n_bad++; $display("FAIL sb_wdata: got %h expected abababab", wo); end
        n_cmp++; if (a !== 30'd6) begin n_bad++; $display("FAIL sb_addr: got %h expected 6", a); end
        run_op(1, 0, 1, 0, 32'h19, 32'h0, 2, 32'h0000ab00, ns, nr, ne, ro, we, a, be, wo, un, hg);
        n_cmp++; if (ro !== 32'hffffffab) begin n_bad++; $display("FAIL lb_data: got %h expected ffffffab", ro); end
        n_cmp++; if (we !== 1'b0 || ns !== 3 || nr !== 2) begin n_bad++; $display("FAIL lb_timing: we=%b stall=%0d req=%0d expected 0/3/2", we, ns, nr); end
        run_op(1, 0, 1, 1, 32'h19, 32'h0, 1, 32'h0000ab00, ns, nr, ne, ro, we, a, be, wo, un, hg);
        n_cmp++; if (ro !== 32'h000000ab) begin n_bad++; $display("FAIL lbu_data: got %h expected 000000ab", ro); end
    endtask

    task automatic test_load_delay();
        int ns, nr, ne; logic [31:0] ro, wo; logic we; logic [29:0] a; logic [3:0] be; bit un, hg;
        run_op(1, 0, 0, 0, 32'h20, 32'h0, 5, 32'h0000447a, ns, nr, ne, ro, we, a, be, wo, un, hg);
        n_cmp++; if (ns !== 6) begin n_bad++; $display("FAIL lw_delay_stall: got %0d expected 6", ns); end
        n_cmp++; if (ro !== 32'h0000447a) begin n_bad++; $display("FAIL lw_delay_data: got %h expected 0000447a", ro); end
        n_cmp++; if (un) begin n_bad++; $display("FAIL lw_delay_stable: outputs changed while mem_req high, expected stable"); end
        // Stores leave the previous load result in place.
        run_op(0, 1, 0, 0, 32'h24, 32'h11112222, 1, 32'h99999999, ns, nr, ne, ro, we, a, be, wo, un, hg);
        n_cmp++; if (ro !== 32'h0000447a) begin n_bad++; $display("FAIL sw_keeps_rd: got %h expected 0000447a", ro); end
    endtask

    task automatic test_illegal();
        int ns, nr, ne; logic [31:0] ro, wo; logic we; logic [29:0] a; logic [3:0] be; bit un, hg;
        run_op(1, 0, 0, 0, 32'h22, 32'h0, 1, 32'h12345678, ns, nr, ne, ro, we, a, be, wo, un, hg);
        n_cmp++; if (nr !== 0 || ns !== 0) begin n_bad++; $display("FAIL misalign_noreq: req=%0d stall=%0d expected 0/0", nr, ns); end
        n_cmp++; if (ne !== 1 || ro !== 32'd0) begin n_bad++; $display("FAIL misalign_err: pulses=%0d rd=%h expected 1/0", ne, ro); end
        run_op(1, 1, 1, 0, 32'h10, 32'h0, 1, 32'h12345678, ns, nr, ne, ro, we, a, be, wo, un, hg);
        n_cmp++; if (nr !== 0 || ns !== 0 || ne !== 1) begin n_bad++; $display("FAIL rw_both: req=%0d stall=%0d err=%0d expected 0/0/1", nr, ns, ne); end
    endtask

    task automatic test_timeout();
        int ns, nr, ne; logic [31:0] ro, wo; logic we; logic [29:0] a; logic [3:0] be; bit un, hg;
        run_op(1, 0, 0, 0, 32'h30, 32'h0, 0, 32'h0, ns, nr, ne, ro, we, a, be, wo, un, hg);
        n_cmp++; if (nr !== TO || ns !== TO + 1 || hg) begin n_bad++; $display("FAIL timeout_len: req=%0d stall=%0d hung=%0b expected %0d/%0d/0", nr, ns, hg, TO, TO + 1); end
        n_cmp++; if (ne !== 1 || ro !== 32'd0) begin n_bad++; $display("FAIL timeout_err: pulses=%0d rd=%h expected 1/0", ne, ro); end
        // Ack on the final allowed cycle is a success.
        run_op(1, 0, 0, 0, 32'h34, 32'h0, TO, 32'hcafe0001, ns, nr, ne, ro, we, a, be, wo, un, hg);
        n_cmp++; if (ne !== 0 || ro !== 32'hcafe0001 || nr !== TO) begin n_bad++; $display("FAIL ack_on_timeout: err=%0d rd=%h req=%0d expected 0/cafe0001/%0d", ne, ro, nr, TO); end
        // Ack one cycle late lands in DONE and is ignored.
        run_op(1, 0, 0, 0, 32'h38, 32'h0, TO + 1, 32'hcafe0002, ns, nr, ne, ro, we, a, be, wo, un, hg);
        n_cmp++; if (ne !== 1 || ro !== 32'd0) begin n_bad++; $display("FAIL late_ack: err=%0d rd=%h expected 1/0", ne, ro); end
    endtask

    task automatic test_async_reset();
        memread_m = 1; memwrite_m = 0; byte_m = 0; unsigned_m = 0;
        aluout_m = 32'h40; writedata_m = 32'h0; mem_ack = 0;
        repeat (2) begin @(posedge clk); #1; end
        #2;
        n_cmp++; if (mem_req !== 1'b1 || stall_m !== 1'b1) begin n_bad++; $display("FAIL areset_pre: req=%b stall=%b expected 1/1", mem_req, stall_m); end
        reset = 0;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || stall_m !== 1'b0) begin n_bad++; $display("FAIL areset_drop: req=%b stall=%b expected 0/0", mem_req, stall_m); end
        memread_m = 0;
        @(posedge clk); #2;
        reset = 1;
        @(posedge clk); #1;
        mem_ack = 1; mem_rdata = 32'hdeadbeef;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b0 || stall_m !== 1'b0) begin n_bad++; $display("FAIL areset_idle: req=%b stall=%b expected 0/0", mem_req, stall_m); end
        @(posedge clk); #1;
        mem_ack = 0;
        @(negedge clk);
        n_cmp++; if (readdata_m !== 32'd0 || err_m !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL areset_stray_ack: rd=%h err=%b req=%b expected 0/0/0", readdata_m, err_m, mem_req); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int ns, nr, ne, ack_at, kind, exp_req;
        logic [31:0] ro, wo, addr, wd, rdata, lane, model_rd, exp_wd;
        logic we, rd, wr, byt, uns, legal, ok;
        logic [29:0] a; logic [3:0] be, exp_be; bit un, hg;
        reset = 0; #3; reset = 1;
        @(posedge clk); #1;
        model_rd = 32'd0;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 9);
            addr = $urandom; wd = $urandom; rdata = $urandom;
            byt = $urandom_range(0, 1); uns = $urandom_range(0, 1);
            rd = $urandom_range(0, 1); wr = !rd;
            if (kind == 0) begin rd = 1; wr = 1; end
            else if (kind == 1) begin byt = 0; if (addr[1:0] == 2'b00) addr[0] = 1'b1; end
            else if (!byt) addr[1:0] = 2'b00;
            ack_at = $urandom_range(0, TO + 2);
            run_op(rd, wr, byt, uns, addr, wd, ack_at, rdata, ns, nr, ne, ro, we, a, be, wo, un, hg);
            // Reference: transaction-level outcome from the access rules.
            legal = (rd != wr) && (byt || addr % 4 == 0);
            if (!legal) begin
                n_cmp++; if (nr !== 0 || ns !== 0 || ne !== 1 || ro !== 32'd0) begin n_bad++; $display("FAIL rnd%0d_illegal: req=%0d stall=%0d err=%0d rd=%h expected 0/0/1/0", t, nr, ns, ne, ro); end
                model_rd = 32'd0;
            end else begin
                ok = (ack_at >= 1) && (ack_at <= TO);
                exp_req = ok ? ack_at : TO;
                exp_be = byt ? 4'(1 << (addr % 4)) : 4'hf;
                exp_wd = byt ? (32'(wd[7:0]) * 32'h01010101) : wd;
                if (!ok) model_rd = 32'd0;
                else if (rd) begin
                    lane = byt ? ((rdata >> (8 * (addr % 4))) & 32'hff) : rdata;
                    if (byt && !uns && lane >= 32'd128) lane = lane | 32'hffffff00;
                    model_rd = lane;
                end
                n_cmp++; if (nr !== exp_req || ns !== exp_req + 1 || hg) begin n_bad++; $display("FAIL rnd%0d_timing: req=%0d stall=%0d expected %0d/%0d", t, nr, ns, exp_req, exp_req + 1); end
                n_cmp++; if (a !== addr[31:2] || be !== exp_be || we !== wr) begin n_bad++; $display("FAIL rnd%0d_ctrl: addr=%h be=%b we=%b expected %h/%b/%b", t, a, be, we, addr[31:2], exp_be, wr); end
                n_cmp++; if (wr && wo !== exp_wd) begin n_bad++; $display("FAIL rnd%0d_wdata: got %h expected %h", t, wo, exp_wd); end
                n_cmp++; if (ro !== model_rd) begin n_bad++; $display("FAIL rnd%0d_rdata: got %h expected %h", t, ro, model_rd); end
                n_cmp++; if (ne !== (ok ? 0 : 1) || un) begin n_bad++; $display("FAIL rnd%0d_err: pulses=%0d unstable=%0b expected %0d/0", t, ne, un, ok ? 0 : 1); end
            end
        end
    endtask

    initial begin
        memread_m = 0; memwrite_m = 0; byte_m = 0; unsigned_m = 0;
        aluout_m = '0; writedata_m = '0; mem_rdata = '0; mem_ack = 0; reset = 0;
        test_reset();
        test_store_word();
        test_byte_ops();
        test_load_delay();
        test_illegal();
        test_timeout();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_stage_ctrl.md
# dmem_stage_ctrl

Memory-stage controller between the EX/MEM pipeline register and a variable-latency data memory in the pipelined MIPS core. It turns `lw`/`sw`/`lb`/`lbu`/`sb` requests into a req/ack memory transaction with byte enables, and stalls the pipeline until the transaction completes. It aligns and sign- or zero-extends load data for the MEM/WB register. Misaligned and illegal accesses, and memory timeouts, are flagged instead of being issued.

## Interface

Parameters:
- `TIMEOUT`, 15: REQ cycles without `mem_ack` before the transaction is aborted (1..255).

Ports:
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low (asserted at 0).
- `memread_m`  input  1  load in MEM stage.
- `memwrite_m`  input  1  store in MEM stage.
- `byte_m`  input  1  byte access (`lb`/`lbu`/`sb`); 0 = word.
- `unsigned_m`  input  1  zero-extend byte load (`lbu`).
- `aluout_m`  input  32  byte address.
- `writedata_m`  input  32  store data.
- `stall_m`  output  1  freeze PC and all pipeline registers up to and including EX/MEM.
- `readdata_m`  output  32  aligned and extended load result.
- `err_m`  output  1  one-cycle error pulse.
- `mem_req`  output  1  memory request, held until ack.
- `mem_we`  output  1  write request.
- `mem_addr`  output  30  word address, `aluout_m[31:2]`.
- `mem_be`  output  4  byte enables, lane i = bits [8i+7:8i] (little-endian).
- `mem_wdata`  output  32  write data.
- `mem_rdata`  input  32  read data, valid when `mem_ack` = 1.
- `mem_ack`  input  1  one-cycle completion.

## Operation

- FSM states: IDLE, REQ, DONE. All `mem_*` outputs, `readdata_m` and `err_m` are registered.
- IDLE, no op: `stall_m` = 0.
- IDLE, legal op: `stall_m` = 1 (combinational). Latch address, be, wdata and type. Go to REQ.
- Legal op means exactly one of `memread_m`/`memwrite_m` is set, and `aluout_m[1:0]` = 0 when `byte_m` = 0.
- IDLE, illegal op (both read and write set, or misaligned word): no request, `stall_m` = 0, `err_m` = 1 next cycle, `readdata_m` = 0. Stay in IDLE.
- REQ: `mem_req` = 1, `stall_m` = 1, timeout counter increments each cycle.
  - `mem_ack` = 1: capture `mem_rdata`, clear counter, go to DONE.
  - Counter reaches `TIMEOUT` with no ack: drop `mem_req`, `readdata_m` = 0, `err_m` pulse in DONE, go to DONE.
  - `mem_ack` arriving on the timeout cycle counts as success.
- DONE: `stall_m` = 0, `readdata_m` valid. The pipeline advances at the end of this cycle. Go to IDLE unconditionally, so a back-to-back memory op is seen in the next IDLE.
- Byte enables: word access = 4'b1111. Byte access = `1 << aluout_m[1:0]`.
- Write data: `sw` passes `writedata_m` through. `sb` replicates `writedata_m[7:0]` to all four lanes.
- Load data:
  - `lw`: `mem_rdata`.
  - `lb`: selected lane sign-extended from bit 7.
  - `lbu`: selected lane zero-extended.
  - Stores leave `readdata_m` unchanged.
- `mem_ack` in IDLE or DONE is ignored.
- Reset (any time, including mid-transaction): state = IDLE; `mem_req`, `mem_we`, `err_m`, `stall_m` = 0; `mem_addr`, `mem_be`, `mem_wdata`, `readdata_m`, counter = 0. An abandoned transaction is not replayed.

## Timing

- Cycle N: op in IDLE, `stall_m` = 1.
- N+1: `mem_req` = 1.
- Ack in cycle K ≥ N+1: DONE in K+1 with `stall_m` = 0 and `readdata_m` valid.
- Minimum occupancy is 3 cycles: 2 stall cycles plus the release cycle.
- Timeout path: `mem_req` high for `TIMEOUT` cycles, DONE with `err_m` = 1 one cycle later.
- `mem_req` never drops before ack or timeout. `mem_addr`/`mem_be`/`mem_wdata`/`mem_we` are stable while `mem_req` = 1.
- Illegal op: `err_m` at N+1, zero stall cycles.

## Test plan

- `sw` of 32'h04ee9112 to address 8, ack on the first REQ cycle -> `mem_addr` = 2, `mem_be` = 4'b1111, `mem_we` = 1, `stall_m` high 2 cycles, low in DONE.
- `sb` of 32'h000000ab to address 0x19, then `lb` and `lbu` at 0x19 with `mem_rdata` = 32'h0000ab00 -> `mem_be` = 4'b0010, `mem_wdata` = 32'habababab; `readdata_m` = 32'hffffffab, then 32'h000000ab.
- `lw` at 0x20, ack delayed 5 cycles, `mem_rdata` = 32'h0000447a -> `stall_m` high 6 cycles, `readdata_m` = 32'h0000447a in DONE.
- `lw` at 0x22 (misaligned), and a separate op with read and write both set -> no `mem_req`, `stall_m` = 0, `err_m` pulses once each.
- `lw` with no ack, `TIMEOUT` = 15 -> `mem_req` high exactly 15 cycles, then `err_m` = 1, `readdata_m` = 0, `stall_m` released.
- `reset` = 0 two cycles into REQ -> `mem_req` and `stall_m` drop asynchronously. After release, state is IDLE and a later ack is ignored.
